flappy_physics: RTL
===================

# flappy_physics

Parametrised per-frame physics engine for the flappy game. It owns the bird position and velocity, N scrolling walls with gaps, the score and the game-over flag. On each frame tick it steps every object in sequence through one shared subtract/add datapath, then checks for collisions. It sits between the frame-rate timer and the VGA draw controller; the draw controller reads its outputs only while `busy` is low.

## Interface
- `COORD_W`, 8: width of all coordinates and of the velocity (velocity is signed).
- `SCORE_W`, 8: score width.
- `NUM_WALLS`, 2: wall count, 1..8.
- `BIRD_X`, 20: fixed bird column. `BIRD_W`/`BIRD_H`, 4/4: bird size.
- `BIRD_Y_START`, 60. `JUMP_VY`, 10. `GRAVITY`, 4. `MAX_FALL`, 12: most negative velocity allowed is −MAX_FALL.
- `WALL_X_START`, 100: position of wall 0. Wall k starts at WALL_X_START + k·WALL_SPACING.
- `WALL_SPACING`, 80. `WALL_SPEED`, 4. `WALL_WIDTH`, 10. `WALL_RESPAWN`, 159.
- `SCREEN_H`, 120. `GAP_H`, 30. `GAP_Y_FIXED`, 40.
- `clk` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse that requests a frame update.
- `jump` in 1: jump request pulse; it may arrive in any cycle.
- `restart` in 1: returns the game to its start state; only honoured in IDLE.
- `busy` out 1: high while an update is in progress.
- `done` out 1: one-cycle pulse when an update completes.
- `game_over` out 1: sticky collision flag.
- `bird_y` out COORD_W: bird top row.
- `wall_x` out NUM_WALLS·COORD_W: wall k occupies bits [k·COORD_W +: COORD_W].
- `gap_y` out NUM_WALLS·COORD_W: top of the gap in each wall.
- `score` out SCORE_W: walls passed.

## Operation
- **FSM states:** IDLE, WALLS, BIRD, CHECK, DONE.
- **IDLE:**
  - `frame_tick` while `game_over`=0 → go to WALLS with wall index 0.
  - `restart` → reload every start value in a single cycle.
  - `restart` and `frame_tick` together: restart wins and the tick is dropped.
- **WALLS:** updates one wall per cycle, wall index 0..NUM_WALLS−1, then goes to BIRD.
  - If wall_x < WALL_SPEED: wall_x ← WALL_RESPAWN and gap_y ← next gap value.
  - Otherwise wall_x ← wall_x − WALL_SPEED.
  - Score increments when old wall_x + WALL_WIDTH ≥ BIRD_X and new wall_x + WALL_WIDTH < BIRD_X.
  - A respawn never scores.
  - Score saturates at 2^SCORE_W−1.
- **BIRD:** one cycle, then goes to CHECK.
  - If jump_pending: vy ← JUMP_VY. Otherwise vy ← max(vy − GRAVITY, −MAX_FALL).
  - jump_pending clears in this cycle.
  - y ← old y − old vy, computed at COORD_W+1 bits.
  - If the result is negative, y clamps to 0 (hitting the ceiling is not fatal).
- **CHECK:** one cycle; sets `game_over` if either condition holds.
  - Floor: y + BIRD_H ≥ SCREEN_H.
  - Wall: any wall overlaps columns [BIRD_X, BIRD_X+BIRD_W) and the bird is not fully inside the gap, i.e. y < gap_y or y + BIRD_H > gap_y + GAP_H.
- **DONE:** pulses `done` for one cycle, then returns to IDLE.
- **jump_pending:**
  - Set by `jump` in any state.
  - A `jump` in the same cycle as the BIRD-state clear keeps it set for the next frame.
  - Cleared by reset and by restart.
- **Arithmetic:** all wall sums are computed at COORD_W+1 bits so they cannot overflow.

## Timing
- **Update latency:** `done` is asserted NUM_WALLS+3 cycles after the cycle in which `frame_tick` is sampled.
- **busy:** high from the cycle after the tick through the DONE cycle.
- **Dropped ticks:** a `frame_tick` arriving while busy is ignored, not queued.
- **Output updates:** outputs change only in WALLS and BIRD, plus `game_over` in CHECK.
- **Reset values:**
  - bird_y = BIRD_Y_START; vy = 0.
  - wall_x[k] = WALL_X_START + k·WALL_SPACING, truncated to COORD_W.
  - gap_y = GAP_Y_FIXED, or the LFSR seed when FLAPPY_LFSR_GAP_EN is defined.
  - score = 0; game_over = 0; busy = 0; done = 0; jump_pending = 0; state = IDLE.
- **Reset mid-update:** all state returns to the reset values immediately, with no `done` pulse.

## Configuration
- **Macro:** `FLAPPY_LFSR_GAP_EN`.
- **Defined:**
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) advances once per respawn.
  - New gap_y = GAP_Y_MIN + (lfsr mod (SCREEN_H − GAP_H − 2·GAP_Y_MIN)), with GAP_Y_MIN = 8.
  - Restart re-seeds the LFSR.
- **Undefined:** no LFSR is built and every gap_y stays at GAP_Y_FIXED.

## Structure
- **Package `flappy_pkg`:**
  - The state enum.
  - GAP_Y_MIN.
  - LFSR seed and taps.
  - The shared colour constants used by the draw controller: BIRD 3'b010, WALL 3'b100, BACKGROUND 3'b111.
- **Sub-module `flappy_lfsr`:** instantiated only under FLAPPY_LFSR_GAP_EN.
- **Shared datapath:** one subtractor and one adder, muxed by state and wall index.

## Test plan
- **Frame latency:** reset, then one `frame_tick` with NUM_WALLS=2 → `done` 5 cycles later; bird_y=60, vy=−4, wall_x={96,176}.
- **Jump:** `jump` pulse, then a tick → vy=10 and bird_y=60; next tick → bird_y=50, vy=6.
- **Fall to floor:** no jumps, repeated ticks → vy saturates at −12; `game_over` is set on the first frame where bird_y+4 ≥ 120, and later ticks are ignored.
- **Respawn and scoring:**
  - Wall at x=2 → next tick gives x=159 with no score change.
  - Wall at x=12 with BIRD_X=20 → new x=8 gives 8+10 < 20, so score increments.
- **Score saturation:** score=255 and another wall passes → score stays 255.
- **Mid-update reset and restart:** `resetn` dropped during WALLS → all outputs show the reset values and no `done` pulse occurs; `restart` after game_over → `game_over`=0 and start values are reloaded.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy physics engine and draw controller.
package flappy_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WALLS,
      S_BIRD,
      S_CHECK,
      S_DONE
   } state_t;

   localparam int GAP_Y_MIN = 8;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Fibonacci taps 8,6,5,4 expressed as a bit mask over q[7:0]
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   localparam logic [2:0] COL_BIRD = 3'b010;
   localparam logic [2:0] COL_WALL = 3'b100;
   localparam logic [2:0] COL_BG   = 3'b111;

endpackage

// File: rtl/flappy_lfsr.sv
// 8-bit Fibonacci LFSR feeding random gap heights on wall respawn.
module flappy_lfsr
   import flappy_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       i_load,
   input  logic       i_adv,
   output logic [7:0] o_q
);

   logic [7:0] r_q;
   logic       w_fb;

   assign w_fb = ^(r_q & LFSR_TAPS);
   assign o_q  = r_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_q <= LFSR_SEED;
      end else if (i_load) begin
         r_q <= LFSR_SEED;
      end else if (i_adv) begin
         r_q <= {r_q[6:0], w_fb};
      end
   end

endmodule

// File: rtl/flappy_physics.sv
// Per-frame physics for the flappy game: walls, bird, collisions, score.
// Optional FLAPPY_LFSR_GAP_EN randomises gap height on each wall respawn.
module flappy_physics
   import flappy_pkg::*;
#(
   parameter int COORD_W      = 8,
   parameter int SCORE_W      = 8,
   parameter int NUM_WALLS    = 2,
   parameter int BIRD_X       = 20,
   parameter int BIRD_W       = 4,
   parameter int BIRD_H       = 4,
   parameter int BIRD_Y_START = 60,
   parameter int JUMP_VY      = 10,
   parameter int GRAVITY      = 4,
   parameter int MAX_FALL     = 12,
   parameter int WALL_X_START = 100,
   parameter int WALL_SPACING = 80,
   parameter int WALL_SPEED   = 4,
   parameter int WALL_WIDTH   = 10,
   parameter int WALL_RESPAWN = 159,
   parameter int SCREEN_H     = 120,
   parameter int GAP_H        = 30,
   parameter int GAP_Y_FIXED  = 40
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           frame_tick,
   input  logic                           jump,
   input  logic                           restart,
   output logic                           busy,
   output logic                           done,
   output logic                           game_over,
   output logic [COORD_W-1:0]             bird_y,
   output logic [NUM_WALLS*COORD_W-1:0]   wall_x,
   output logic [NUM_WALLS*COORD_W-1:0]   gap_y,
   output logic [SCORE_W-1:0]             score
);

   localparam int CW1   = COORD_W + 1;
   localparam int IDX_W = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
   localparam int OLD_TH_I = BIRD_X - WALL_WIDTH;
   localparam int OV_LO_I  = BIRD_X - WALL_WIDTH + 1;

   localparam logic [IDX_W-1:0]      K_LAST  = IDX_W'(NUM_WALLS - 1);
   localparam logic [COORD_W-1:0]    K_Y0    = COORD_W'(BIRD_Y_START);
   localparam logic [COORD_W-1:0]    K_RESP  = COORD_W'(WALL_RESPAWN);
   localparam logic [COORD_W-1:0]    K_JUMP  = COORD_W'(JUMP_VY);
   localparam logic [COORD_W-1:0]    K_GAPF  = COORD_W'(GAP_Y_FIXED);
   localparam logic [CW1-1:0]        K_SPEED = CW1'(WALL_SPEED);
   localparam logic [CW1-1:0]        K_WW    = CW1'(WALL_WIDTH);
   localparam logic [CW1-1:0]        K_BX    = CW1'(BIRD_X);
   localparam logic [CW1-1:0]        K_BH    = CW1'(BIRD_H);
   localparam logic [CW1-1:0]        K_SH    = CW1'(SCREEN_H);
   localparam logic [CW1-1:0]        K_GH    = CW1'(GAP_H);
   localparam logic [CW1-1:0]        K_NGRAV = CW1'(-GRAVITY);
   localparam logic signed [CW1-1:0] K_NMAX  = CW1'(-MAX_FALL);
   localparam logic [CW1-1:0]        K_OV_HI = CW1'(BIRD_X + BIRD_W);
   localparam logic [CW1-1:0]        K_OV_LO =
      (OV_LO_I > 0) ? CW1'(OV_LO_I) : '0;
   localparam logic [CW1-1:0]        K_OLD_TH =
      (OLD_TH_I > 0) ? CW1'(OLD_TH_I) : '0;

   function automatic logic [COORD_W-1:0] wall_start(input int k);
      return COORD_W'(WALL_X_START + k * WALL_SPACING);
   endfunction

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [IDX_W-1:0]            r_idx;
   logic [COORD_W-1:0]          r_bird_y;
   logic signed [COORD_W-1:0]   r_vy;
   logic [COORD_W-1:0]          r_wall_x [NUM_WALLS];
   logic [COORD_W-1:0]          r_gap_y  [NUM_WALLS];
   logic [SCORE_W-1:0]          r_score;
   logic                        r_game_over;
   logic                        r_jump;

   logic [COORD_W-1:0]          w_old_x;
   logic [CW1-1:0]              w_sub_a;
   logic [CW1-1:0]              w_sub_b;
   logic [CW1-1:0]              w_sub;
   logic [CW1-1:0]              w_add_a;
   logic [CW1-1:0]              w_add_b;
   logic [CW1-1:0]              w_add;
   logic                        w_reload;
   logic                        w_respawn;
   logic                        w_score_inc;
   logic [COORD_W-1:0]          w_gap_new;
   logic [COORD_W-1:0]          w_new_y;
   logic [COORD_W-1:0]          w_new_vy;
   logic                        w_floor_hit;
   logic                        w_wall_hit;

   assign w_reload = (r_state == S_IDLE) && restart;

`ifdef FLAPPY_LFSR_GAP_EN
   localparam int GAP_RANGE = SCREEN_H - GAP_H - 2 * GAP_Y_MIN;
   localparam logic [COORD_W-1:0] K_GAP_RST = COORD_W'(LFSR_SEED);

   logic [7:0] w_lfsr;

   flappy_lfsr u_lfsr (
      .clk    (clk),
      .resetn (resetn),
      .i_load (w_reload),
      .i_adv  ((r_state == S_WALLS) && w_respawn),
      .o_q    (w_lfsr)
   );

   assign w_gap_new = COORD_W'(GAP_Y_MIN + (int'(w_lfsr) % GAP_RANGE));
`else
   localparam logic [COORD_W-1:0] K_GAP_RST = K_GAPF;

   assign w_gap_new = K_GAPF;
`endif

   assign w_old_x = r_wall_x[r_idx];

   // One subtractor and one adder, operands steered by the current state
   always_comb begin
      w_sub_a = {1'b0, w_old_x};
      w_sub_b = K_SPEED;
      if (r_state == S_BIRD) begin
         w_sub_a = {1'b0, r_bird_y};
         w_sub_b = {r_vy[COORD_W-1], r_vy};
      end
      w_sub = w_sub_a - w_sub_b;

      w_add_a = {1'b0, w_sub[COORD_W-1:0]};
      w_add_b = K_WW;
      if (r_state == S_BIRD) begin
         w_add_a = {r_vy[COORD_W-1], r_vy};
         w_add_b = K_NGRAV;
      end else if (r_state == S_CHECK) begin
         w_add_a = {1'b0, r_bird_y};
         w_add_b = K_BH;
      end
      w_add = w_add_a + w_add_b;
   end

   assign w_respawn   = {1'b0, w_old_x} < K_SPEED;
   assign w_score_inc = !w_respawn
                     && ({1'b0, w_old_x} >= K_OLD_TH)
                     && (w_add < K_BX);

   assign w_new_y  = w_sub[COORD_W] ? '0 : w_sub[COORD_W-1:0];
   assign w_new_vy = r_jump ? K_JUMP
                   : ($signed(w_add) < K_NMAX) ? K_NMAX[COORD_W-1:0]
                   : w_add[COORD_W-1:0];

   assign w_floor_hit = w_add >= K_SH;

   always_comb begin
      w_wall_hit = 1'b0;
      for (int k = 0; k < NUM_WALLS; k++) begin
         if (({1'b0, r_wall_x[k]} < K_OV_HI)
             && ({1'b0, r_wall_x[k]} >= K_OV_LO)
             && (({1'b0, r_bird_y} < {1'b0, r_gap_y[k]})
                 || (w_add > ({1'b0, r_gap_y[k]} + K_GH)))) begin
            w_wall_hit = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b1;
      done        = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (!restart && frame_tick && !r_game_over) begin
               w_state_nxt = S_WALLS;
            end
         end
         S_WALLS: begin
            if (r_idx == K_LAST) begin
               w_state_nxt = S_BIRD;
            end
         end
         S_BIRD:  w_state_nxt = S_CHECK;
         S_CHECK: w_state_nxt = S_DONE;
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            busy        = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_bird_y    <= K_Y0;
         r_vy        <= '0;
         r_score     <= '0;
         r_game_over <= 1'b0;
         r_jump      <= 1'b0;
         for (int k = 0; k < NUM_WALLS; k++) begin
            r_wall_x[k] <= wall_start(k);
            r_gap_y[k]  <= K_GAP_RST;
         end
      end else begin
         r_state <= w_state_nxt;
         // a jump landing on the clearing cycle survives into the next frame
         r_jump  <= jump | (r_jump & (r_state != S_BIRD));

         if (r_state == S_IDLE) begin
            r_idx <= '0;
         end

         if (w_reload) begin
            r_bird_y    <= K_Y0;
            r_vy        <= '0;
            r_score     <= '0;
            r_game_over <= 1'b0;
            r_jump      <= 1'b0;
            for (int k = 0; k < NUM_WALLS; k++) begin
               r_wall_x[k] <= wall_start(k);
               r_gap_y[k]  <= K_GAP_RST;
            end
         end

         if (r_state == S_WALLS) begin
            r_idx           <= r_idx + IDX_W'(1);
            r_wall_x[r_idx] <= w_respawn ? K_RESP : w_sub[COORD_W-1:0];
            if (w_respawn) begin
               r_gap_y[r_idx] <= w_gap_new;
            end
            if (w_score_inc && (r_score != '1)) begin
               r_score <= r_score + SCORE_W'(1);
            end
         end

         if (r_state == S_BIRD) begin
            r_bird_y <= w_new_y;
            r_vy     <= w_new_vy;
         end

         if ((r_state == S_CHECK) && (w_floor_hit || w_wall_hit)) begin
            r_game_over <= 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NUM_WALLS; k++) begin : g_pack
      assign wall_x[k*COORD_W +: COORD_W] = r_wall_x[k];
      assign gap_y[k*COORD_W +: COORD_W]  = r_gap_y[k];
   end

   assign bird_y    = r_bird_y;
   assign score     = r_score;
   assign game_over = r_game_over;

endmodule
